// File: rtl/switch_debounce.sv
// switch_debounce: 2-flop sync plus tick-prescaled per-bit debounce; ports: clk, rst (async active-low), raw_in pins -> sw_out levels, sw_rise/sw_fall one-cycle edge pulses, tick prescaler strobe
module switch_debounce #(
  parameter int WIDTH        = 24,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             tick
);
  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  logic [WIDTH-1:0] s1_q, s2_q, sw_q, sw_d, rise_q, rise_d, fall_q, fall_d, flip;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  assign tick    = div_q == DIV_MAX;
  assign sw_out  = sw_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    for (int i = 0; i < WIDTH; i++) begin
      flip[i]  = s2_q[i] != sw_q[i] && tick && cnt_q[i] == CNT_MAX;
      cnt_d[i] = (s2_q[i] == sw_q[i] || flip[i]) ? '0 : tick ? cnt_q[i] + CW'(1) : cnt_q[i];
    end
    sw_d   = sw_q ^ flip;
    rise_d = flip & s2_q;
    fall_d = flip & ~s2_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      div_q  <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      s1_q   <= raw_in;
      s2_q   <= s1_q;
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: vectors, corner sequences and random stimulus against a tick-counting reference model
module tb_switch_debounce;
  logic clk, rst, chk_en;
  logic [23:0] raw_in, sw_out, sw_rise, sw_fall;
  logic tick;
  int total = 0, bad = 0, lat;
  switch_debounce #(.WIDTH(24), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .sw_out(sw_out),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .tick(tick)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask
  task automatic measure(input int b, input logic lvl, output int l);
    l = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (sw_out[b] === lvl) begin
        l = k;
        break;
      end
    end
  endtask
  // Reference: n = cycles since release, ticks fall on n%4==3; a bit flips at the
  // tick where the current disagreement run [start, n] has covered 3 tick cycles.
  logic [23:0] m_s1, m_s2, m_sw, m_rise, m_fall, m_flip;
  int n;
  int start [24];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_sw = '0; m_rise = '0; m_fall = '0; n = 0;
      for (int i = 0; i < 24; i++) start[i] = -1;
    end else begin
      m_flip = '0;
      for (int i = 0; i < 24; i++) begin
        if (m_s2[i] == m_sw[i]) start[i] = -1;
        else begin
          if (start[i] < 0) start[i] = n;
          if (n % 4 == 3 && (n + 1) / 4 - start[i] / 4 == 3) begin
            m_flip[i] = 1'b1;
            start[i] = -1;
          end
        end
      end
      m_rise = m_flip & m_s2;
      m_fall = m_flip & ~m_s2;
      m_sw = m_sw ^ m_flip;
      m_s2 = m_s1;
      m_s1 = raw_in;
      n++;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("model sw_out", sw_out, m_sw);
    chk("model sw_rise", sw_rise, m_rise);
    chk("model sw_fall", sw_fall, m_fall);
    chk("model tick", {23'b0, tick}, {23'b0, n % 4 == 3});
  end
  typedef struct { logic [23:0] raw; int hold; logic [23:0] exp; } vec_t;
  vec_t vecs [9];
  initial begin
    vecs[0] = '{24'h000001, 16, 24'h000001};
    vecs[1] = '{24'h000000, 16, 24'h000000};
    vecs[2] = '{24'h0FF00F, 16, 24'h0FF00F};
    vecs[3] = '{24'hFFFFFF,  5, 24'h0FF00F};
    vecs[4] = '{24'h0FF00F, 16, 24'h0FF00F};
    vecs[5] = '{24'hF00FF0, 16, 24'hF00FF0};
    vecs[6] = '{24'h000000,  4, 24'hF00FF0};
    vecs[7] = '{24'hF00FF0, 16, 24'hF00FF0};
    vecs[8] = '{24'hA5A5A5, 16, 24'hA5A5A5};
    chk_en = 0;
    rst = 0;
    raw_in = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    chk("reset sw_out", sw_out, 0);
    chk("reset sw_rise", sw_rise, 0);
    chk("reset sw_fall", sw_fall, 0);
    chk("reset tick", {23'b0, tick}, 0);
    @(negedge clk) rst = 1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1 chk("first tick", {23'b0, tick}, {23'b0, e == 3});
    end
    @(negedge clk) raw_in = 0;
    repeat (20) @(posedge clk);
    @(negedge clk) raw_in[0] = 1;
    measure(0, 1, lat);
    chk_rng("step latency", lat, 11, 14);
    chk("step rise", sw_rise, 24'h000001);
    chk("step fall", sw_fall, 0);
    @(posedge clk);
    #1 chk("step rise end", sw_rise, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) raw_in[5] = (k % 2 == 0);
      repeat (3) @(posedge clk);
      #1 chk("bounce hold", {23'b0, sw_out[5]}, 0);
    end
    @(negedge clk) raw_in[5] = 1;
    measure(5, 1, lat);
    chk_rng("bounce latency", lat, 11, 14);
    chk("bounce rise", sw_rise, 24'h000020);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk("bounce single pulse", {23'b0, sw_rise[5]}, 0);
    end
    @(negedge clk) raw_in[20] = 1;
    repeat (16) @(posedge clk);
    @(negedge clk) raw_in[20] = 0;
    measure(20, 0, lat);
    chk_rng("fall latency", lat, 11, 14);
    chk("fall pulse", sw_fall, 24'h100000);
    chk("fall no rise", sw_rise, 0);
    @(negedge clk) raw_in = 0;
    repeat (16) @(posedge clk);
    @(negedge clk) raw_in = 24'h0FF00F;
    measure(0, 1, lat);
    chk("simul sw_out", sw_out, 24'h0FF00F);
    chk("simul rise", sw_rise, 24'h0FF00F);
    @(posedge clk);
    #1 chk("simul rise end", sw_rise, 0);
    @(negedge clk) raw_in = 24'h0FF007;
    repeat (16) @(posedge clk);
    #1 chk("pre-reset sw_out", sw_out, 24'h0FF007);
    @(negedge clk) raw_in[3] = 1;
    repeat (10) @(posedge clk);
    #2 rst = 0;
    #1 chk("midreset sw_out", sw_out, 0);
    chk("midreset rise", sw_rise, 0);
    chk("midreset fall", sw_fall, 0);
    @(negedge clk) rst = 1;
    measure(3, 1, lat);
    chk_rng("requalify latency", lat, 11, 14);
    chk("requalify sw_out", sw_out, 24'h0FF00F);
    foreach (vecs[v]) begin
      @(negedge clk) raw_in = vecs[v].raw;
      repeat (vecs[v].hold) @(posedge clk);
      #1 chk($sformatf("vec%0d sw_out", v), sw_out, vecs[v].exp);
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) raw_in = raw_in ^ 24'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 0;
        @(negedge clk) rst = 1;
      end
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
